// File: rtl/filt_accum.sv
// -----------------------------------------------------------------------------
// filt_accum
//   Window accumulator behind the signed pixel x coefficient multiplier.
//   Sums TAPS consecutive A(8,15) products, rounds half-up to an integer,
//   clips to the unsigned pixel range and emits one pixel per window with a
//   single-cycle valid strobe. There is no backpressure.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_valid   in_data holds a valid product this cycle
//   in_data    signed product, A(PIX_BIT, COFCNT_BIT-1)
//   clr        synchronous abort of the partial window (beats in_valid)
//   pix_out    filtered pixel, U(PIX_BIT,0), holds between strobes
//   pix_valid  one-cycle strobe, pix_out/pix_sat are new
//   pix_sat    pix_out was clipped (qualified by pix_valid)
//   busy       a partial window is in progress (tap count != 0)
// -----------------------------------------------------------------------------
module filt_accum #(
    parameter int PIX_BIT    = 8,
    parameter int COFCNT_BIT = 16,
    parameter int TAPS       = 9,
    parameter int GUARD      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [COFCNT_BIT+PIX_BIT-1:0] in_data,
    input  logic                          clr,
    output logic [PIX_BIT-1:0]            pix_out,
    output logic                          pix_valid,
    output logic                          pix_sat,
    output logic                          busy
);

    localparam int IN_W  = COFCNT_BIT + PIX_BIT;
    localparam int ACC_W = IN_W + GUARD;
    localparam int FRAC  = COFCNT_BIT - 1;
    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TAPS - 1);
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(64'd1 << (FRAC - 1));
    localparam logic [PIX_BIT-1:0]      PIX_MAX  = '1;

    // Window phase is fully implied by the tap counter.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic [PIX_BIT-1:0]      pix_out_q,   pix_out_d;
    logic                    pix_valid_q, pix_valid_d;
    logic                    pix_sat_q,   pix_sat_d;

    state_e                  state;
    logic                    last_tap;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] r;
    logic                    r_neg;
    logic                    r_over;

    assign state    = (cnt_q == '0) ? ST_IDLE : ST_ACC;
    assign last_tap = (cnt_q == CNT_LAST);

    // Datapath for the closing tap. GUARD bits make overflow impossible for
    // TAPS full-scale products, so the rounding add can stay in ACC_W bits.
    assign in_ext = {{GUARD{in_data[IN_W-1]}}, in_data};
    assign sum    = acc_q + in_ext;
    assign rnd    = sum + HALF;
    assign r      = rnd >>> FRAC;
    assign r_neg  = r[ACC_W-1];
    assign r_over = !r_neg && (r[ACC_W-1:PIX_BIT] != '0);

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        pix_out_d   = pix_out_q;
        pix_sat_d   = pix_sat_q;
        pix_valid_d = 1'b0;

        if (clr) begin
            // Abort drops any coincident product, last tap included.
            cnt_d = '0;
            acc_d = '0;
        end else if (in_valid) begin
            if (last_tap) begin
                cnt_d       = '0;
                acc_d       = '0;
                pix_valid_d = 1'b1;
                if (r_neg) begin
                    pix_out_d = '0;
                    pix_sat_d = 1'b1;
                end else if (r_over) begin
                    pix_out_d = PIX_MAX;
                    pix_sat_d = 1'b1;
                end else begin
                    pix_out_d = r[PIX_BIT-1:0];
                    pix_sat_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            pix_sat_q   <= pix_sat_d;
        end
    end

    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign pix_sat   = pix_sat_q;
    assign busy      = (state == ST_ACC);

endmodule

// File: tb/tb_filt_accum.sv
// Directed bench for filt_accum: box filter, saturation, rounding edges,
// gapped and back-to-back windows, clr abort and asynchronous reset.
module tb_filt_accum;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        clr = 1'b0;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_sat;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int last_t   = 0;
    int prev_t   = 0;
    int s0;

    filt_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .pix_sat   (pix_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            strobes <= strobes + 1;
            prev_t  <= last_t;
            last_t  <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input int v);
        in_valid = 1'b1;
        in_data  = 24'(v);
        tick();
        in_valid = 1'b0;
        in_data  = 24'($urandom);
    endtask

    // Eight copies of 'body' then 'last'; optional random idle gaps.
    // Returns right after the last-tap edge, when the strobe is visible.
    task automatic window(input int body, input int last, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            tap(body);
            if (gaps) repeat ($urandom_range(0, 3)) tick();
        end
        tap(last);
    endtask

    // Window whose strobe is checked for value, sat flag and 1-cycle width.
    task automatic win_check(input string tag, input int body, input int last,
                             input bit gaps, input int exp_pix, input int exp_sat);
        s0 = strobes;
        window(body, last, gaps);
        check({tag, "_valid"}, int'(pix_valid), 1);
        check({tag, "_pix"},   int'(pix_out),   exp_pix);
        check({tag, "_sat"},   int'(pix_sat),   exp_sat);
        check({tag, "_busy"},  int'(busy),      0);
        tick();
        check({tag, "_valid_drop"}, int'(pix_valid), 0);
        check({tag, "_pix_hold"},   int'(pix_out),   exp_pix);
        check({tag, "_nstrobe"},    strobes - s0,    1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_pix",   int'(pix_out),   0);
        check("rst_valid", int'(pix_valid), 0);
        check("rst_sat",   int'(pix_sat),   0);
        check("rst_busy",  int'(busy),      0);
        reset = 1'b1;
        tick();

        // Box filter and saturation
        win_check("box",     364100,   364100,   1'b0, 100, 0);
        win_check("pos_sat", 8355585,  8355585,  1'b0, 255, 1);
        win_check("neg_sat", -8355840, -8355840, 1'b0, 0,   1);

        // Rounding boundary
        win_check("rnd_p16384", 0, 16384,  1'b0, 1, 0);
        win_check("rnd_p16383", 0, 16383,  1'b0, 0, 0);
        win_check("rnd_n16384", 0, -16384, 1'b0, 0, 0);
        win_check("rnd_n16385", 0, -16385, 1'b0, 0, 1);

        // Gapped window
        win_check("gapped", 364100, 364100, 1'b1, 100, 0);

        // Busy during a window
        tap(364100);
        check("busy_mid", int'(busy), 1);
        check("valid_mid", int'(pix_valid), 0);
        for (int i = 0; i < 7; i++) tap(364100);
        tap(364100);
        check("busy_win_pix", int'(pix_out), 100);
        tick();

        // Two windows back-to-back
        s0 = strobes;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 24'(364100);
            tick();
        end
        check("b2b_valid1", int'(pix_valid), 1);
        check("b2b_pix1",   int'(pix_out),   100);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 24'(182050);
            tick();
        end
        in_valid = 1'b0;
        check("b2b_valid2", int'(pix_valid), 1);
        check("b2b_pix2",   int'(pix_out),   50);
        tick();
        check("b2b_nstrobe", strobes - s0,     2);
        check("b2b_spacing", last_t - prev_t, 9);

        // clr mid-window with a coincident product
        s0 = strobes;
        for (int i = 0; i < 4; i++) tap(364100);
        in_valid = 1'b1;
        clr      = 1'b1;
        in_data  = 24'(364100);
        tick();
        in_valid = 1'b0;
        clr      = 1'b0;
        check("clr_busy",  int'(busy),      0);
        check("clr_valid", int'(pix_valid), 0);
        window(182050, 182050, 1'b0);
        check("clr_pix", int'(pix_out), 50);
        tick();
        check("clr_nstrobe", strobes - s0, 1);

        // clr coincident with a last tap drops the window
        s0 = strobes;
        for (int i = 0; i < 8; i++) tap(364100);
        in_valid = 1'b1;
        clr      = 1'b1;
        tick();
        in_valid = 1'b0;
        clr      = 1'b0;
        tick();
        check("clr_last_nstrobe", strobes - s0, 0);
        check("clr_last_busy",    int'(busy),   0);
        check("clr_last_pix",     int'(pix_out), 50);

        // Async reset mid-window, no clock edge in between
        for (int i = 0; i < 5; i++) tap(364100);
        check("pre_rst_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pix",  int'(pix_out), 0);
        check("arst_busy", int'(busy),    0);
        check("arst_sat",  int'(pix_sat), 0);
        tick();
        reset = 1'b1;
        tick();
        win_check("post_rst", 364100, 364100, 1'b0, 100, 0);

        // Async reset clears a strobe in flight
        window(8355585, 8355585, 1'b0);
        check("inflight_valid", int'(pix_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        check("inflight_clr_valid", int'(pix_valid), 0);
        check("inflight_clr_sat",   int'(pix_sat),   0);
        tick();
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/filt_accum.md
# filt_accum

Downstream stage of the signed pixel×coefficient multiplier in the spatial filter datapath. Accumulates TAPS consecutive A(8,15) products belonging to one filter window, rounds to integer, saturates to the unsigned pixel range, and emits one output pixel per window with a single-cycle valid strobe. There is no backpressure, because the multiplier stage has none.

## Interface
- PIX_BIT, 8, output pixel width, U(8,0)
- COFCNT_BIT, 16, coefficient width, A(0,15); fractional bits FRAC = COFCNT_BIT-1
- TAPS, 9, products per window (3×3 kernel)
- GUARD, 4, accumulator guard bits, ≥ ceil(log2(TAPS))
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  in_data carries a valid product this cycle
- in_data  in  COFCNT_BIT+PIX_BIT (24)  signed product A(8,15) from the multiplier
- clr  in  1  synchronous abort of the current partial window
- pix_out  out  PIX_BIT  filtered pixel, U(8,0)
- pix_valid  out  1  one-cycle strobe; pix_out is new
- pix_sat  out  1  pix_out was clipped (qualified by pix_valid)
- busy  out  1  partial window in progress (tap count ≠ 0)

## Operation
- Registers: tap counter cnt (0..TAPS-1), signed accumulator acc (COFCNT_BIT+PIX_BIT+GUARD = 28 bits), pix_out, pix_valid, pix_sat.
- States, derived from cnt:
  - IDLE: cnt=0, acc=0.
  - ACC: cnt>0.
- in_valid=1 and cnt<TAPS-1: acc ← acc + sext(in_data); cnt ← cnt+1.
- in_valid=1 and cnt=TAPS-1 (last tap):
  - sum = acc + sext(in_data).
  - r = (sum + 2^(FRAC-1)) >>> FRAC, arithmetic shift, i.e. round half up.
  - r<0: pix_out ← 0, pix_sat ← 1.
  - r>2^PIX_BIT-1: pix_out ← 255, pix_sat ← 1.
  - Otherwise: pix_out ← r[7:0], pix_sat ← 0.
  - pix_valid ← 1; acc ← 0; cnt ← 0.
- in_valid=0: acc and cnt hold. Gaps between taps are allowed and do not change the result.
- clr=1: acc ← 0, cnt ← 0, no output generated. clr has priority over a coincident in_valid; that product is dropped, including a last tap.
- pix_valid=0 on every cycle not completing a window. pix_out and pix_sat hold their last values between strobes.
- Width rule: worst-case |sum| = TAPS·255·2^15 = 75,202,560 < 2^27, so 28 bits never overflow. Rounding is done in 28 bits before the shift.

## Timing
- Reset (reset=0, async) sets: cnt=0, acc=0, pix_out=0, pix_valid=0, pix_sat=0, busy=0. Release is synchronous to clk.
- Latency: pix_valid is high in the cycle after the edge that samples the last tap's in_valid. One register stage.
- Throughput: one product per cycle. Back-to-back windows are allowed; at the last-tap edge acc clears, so tap 0 of the next window may arrive on the very next cycle. Maximum output rate is one pixel per TAPS cycles.
- busy = (cnt≠0), registered-derived.
- Reset asserted mid-window: the partial sum is lost immediately. Any pix_valid strobe in flight is cleared.
- clr and reset never produce a pix_valid strobe.

## Test plan
- Box filter: 9 products of 100×3641 (=364,100) on consecutive cycles. Sum 3,276,900, rounded → pix_out=100, pix_sat=0, pix_valid exactly 1 cycle, 1 cycle after the 9th tap.
- Positive saturation: 9 products of 255×32767 (=8,355,585) → pix_out=255, pix_sat=1. Negative saturation: 9 products of 255×(−32768) (=−8,355,840) → pix_out=0, pix_sat=1.
- Rounding boundary:
  - 8 zeros + 16384 → pix_out=1.
  - 8 zeros + 16383 → pix_out=0.
  - 8 zeros + (−16384) → pix_out=0, pix_sat=0.
  - 8 zeros + (−16385) → pix_out=0, pix_sat=1.
- Gapped and back-to-back input:
  - Box-filter window with random idle cycles between taps → same pix_out=100.
  - Two windows fully back-to-back (values 100 then 50) → two strobes 9 cycles apart, pix_out=100 then 50.
- clr mid-window: 4 taps of 364,100, then clr coincident with a 5th valid product, then a full window of 9×182,050 → single strobe, pix_out=50; busy=0 the cycle after clr.
- Async reset mid-window: reset=0 between clock edges after 5 taps → all outputs 0 without a clock edge. After release, a full box window gives pix_out=100.
